multiword_add_ctrl: RTL and testbench

- Sequencer that performs WORDS×16-bit add/subtract by time-multiplexing one external 16-bit adder slice (P/C summation datapath), least-significant slice first, chaining carry between cycles.
- Valid/ready handshake on both operand input and result output.
- Sits between an operand source (ALU front end) and the shared 16-bit adder.

---
 rtl/multiword_add_ctrl.sv | 142 ++++++++++++++
 tb/tb_multiword_add_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_ctrl.sv
// multiword_add_ctrl: sequences a WORDS x 16-bit add/subtract through one
// shared external 16-bit adder slice, least-significant slice first, with
// the carry chained between cycles. Valid/ready on both operand and result.
module multiword_add_ctrl #(
  parameter int unsigned WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*WORDS-1:0] in_a,
  input  logic [16*WORDS-1:0] in_b,
  input  logic                in_sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] out_sum,
  output logic                out_cout,
  output logic                out_ovf,
  output logic [15:0]         adder_a,
  output logic [15:0]         adder_b,
  output logic                adder_cin,
  input  logic [15:0]         adder_s,
  input  logic                adder_cout
);

  localparam int unsigned W     = 16 * WORDS;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q,     state_d;
  logic [IDX_W-1:0] idx_q,       idx_d;
  logic             carry_q,     carry_d;
  logic [W-1:0]     a_q,         a_d;
  logic [W-1:0]     b_q,         b_d;
  logic [W-1:0]     sum_q,       sum_d;
  logic             cout_q,      cout_d;
  logic             ovf_q,       ovf_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;

  // Next-state, datapath update and adder-slice drive
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    adder_a     = 16'h0000;
    adder_b     = 16'h0000;
    adder_cin   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1: invert B once, seed carry with 1
          a_d        = in_a;
          b_d        = in_sub ? ~in_b : in_b;
          carry_d    = in_sub;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        adder_a   = a_q[{idx_q, 4'b0000} +: 16];
        adder_b   = b_q[{idx_q, 4'b0000} +: 16];
        adder_cin = carry_q;
        sum_d[{idx_q, 4'b0000} +: 16] = adder_s;
        carry_d   = adder_cout;
        if (idx_q == IDX_LAST) begin
          cout_d      = adder_cout;
          ovf_d       = (a_q[W-1] == b_q[W-1]) && (adder_s[15] != a_q[W-1]);
          idx_d       = '0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Bench for multiword_add_ctrl (WORDS=4): table of hand-computed vectors
// plus directed backpressure and mid-operation reset sequences.
module tb_multiword_add_ctrl;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          out_ovf;
  logic [15:0]   adder_a;
  logic [15:0]   adder_b;
  logic          adder_cin;
  logic [15:0]   adder_s;
  logic          adder_cout;

  int checks = 0;
  int errors = 0;

  multiword_add_ctrl #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .adder_a   (adder_a),
    .adder_b   (adder_b),
    .adder_cin (adder_cin),
    .adder_s   (adder_s),
    .adder_cout(adder_cout)
  );

  // External 16-bit adder slice
  assign {adder_cout, adder_s} = 17'(adder_a) + 17'(adder_b) + 17'(adder_cin);

  always #10 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
    logic [3:0]   exp_cin;   // bit i = carry-in presented to slice i
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Present an operand at a negedge, let the next posedge accept it,
  // then scramble the inputs to show they are sampled only once.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = {$urandom, $urandom};
    in_b     = {$urandom, $urandom};
    in_sub   = ~sub;
  endtask

  // Called at the negedge after the accept edge; counts edges to out_valid.
  task automatic wait_done(output int cycles, output logic [3:0] cin_seen, output logic ready_low);
    cycles    = 0;
    cin_seen  = 4'b0000;
    ready_low = 1'b1;
    while (!out_valid && cycles < 50) begin
      if (cycles < 4) cin_seen[cycles] = adder_cin;
      if (in_ready) ready_low = 1'b0;
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int         cyc;
    logic [3:0] cin_seen;
    logic       ready_low;

    vecs[0] = '{"add_ffff_1",  64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
                64'h0000_0000_0001_0000, 1'b0, 1'b0, 4'b0010};
    vecs[1] = '{"add_allf_1",  64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
                64'h0, 1'b1, 1'b0, 4'b1110};
    vecs[2] = '{"add_maxpos_1", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, 1'b1, 4'b1110};
    vecs[3] = '{"sub_5_7",     64'h5, 64'h7, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 4'b0001};
    vecs[4] = '{"sub_7_5",     64'h7, 64'h5, 1'b1,
                64'h2, 1'b1, 1'b0, 4'b1111};
    vecs[5] = '{"sub_minneg_1", 64'h8000_0000_0000_0000, 64'h1, 1'b1,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 4'b0001};
    vecs[6] = '{"add_1234",    64'h1234, 64'h1111, 1'b0,
                64'h2345, 1'b0, 1'b0, 4'b0000};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    out_ready = 1'b0;

    #25;
    chk("rst_in_ready",  64'(in_ready),  64'h1);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_sum",   out_sum,        64'h0);
    chk("rst_out_cout",  64'(out_cout),  64'h0);
    chk("rst_out_ovf",   64'(out_ovf),   64'h0);
    chk("rst_adder_a",   64'(adder_a),   64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk({vecs[i].name, "_in_ready"}, 64'(in_ready), 64'h1);
      start_op(vecs[i].a, vecs[i].b, vecs[i].sub);
      wait_done(cyc, cin_seen, ready_low);
      chk({vecs[i].name, "_latency"},  64'(cyc),           64'd4);
      chk({vecs[i].name, "_cin"},      64'(cin_seen),      64'(vecs[i].exp_cin));
      chk({vecs[i].name, "_busy"},     64'(ready_low),     64'h1);
      chk({vecs[i].name, "_sum"},      out_sum,            vecs[i].exp_sum);
      chk({vecs[i].name, "_cout"},     64'(out_cout),      64'(vecs[i].exp_cout));
      chk({vecs[i].name, "_ovf"},      64'(out_ovf),       64'(vecs[i].exp_ovf));
      chk({vecs[i].name, "_done_rdy"}, 64'(in_ready),      64'h0);
      handshake();
      chk({vecs[i].name, "_released"}, 64'(out_valid),     64'h0);
    end

    // Backpressure: result held while a second request waits on in_valid
    start_op(64'h1, 64'h2, 1'b0);
    wait_done(cyc, cin_seen, ready_low);
    chk("bp_latency", 64'(cyc), 64'd4);
    in_valid = 1'b1;
    in_a     = 64'h0000_0000_0000_FFFF;
    in_b     = 64'h1;
    in_sub   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_sum_stable", out_sum,         64'h3);
      chk("bp_valid_held", 64'(out_valid),  64'h1);
      chk("bp_in_ready",   64'(in_ready),   64'h0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle_ready", 64'(in_ready),  64'h1);
    chk("bp_idle_valid", 64'(out_valid), 64'h0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_accepted", 64'(in_ready), 64'h0);
    wait_done(cyc, cin_seen, ready_low);
    chk("bp2_latency", 64'(cyc),      64'd4);
    chk("bp2_sum",     out_sum,       64'h0000_0000_0001_0000);
    chk("bp2_cout",    64'(out_cout), 64'h0);
    handshake();

    // Reset while the third slice is on the adder
    start_op(64'h0003_0002_0001_0000, 64'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mid_slice2_a", 64'(adder_a), 64'h2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'h0);
    chk("mid_rst_sum",   out_sum,        64'h0);
    chk("mid_rst_a",     64'(adder_a),   64'h0);
    chk("mid_rst_b",     64'(adder_b),   64'h0);
    chk("mid_rst_cin",   64'(adder_cin), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(in_ready), 64'h1);
    start_op(64'h1234, 64'h1111, 1'b0);
    wait_done(cyc, cin_seen, ready_low);
    chk("post_rst_latency", 64'(cyc), 64'd4);
    chk("post_rst_sum",     out_sum,  64'h2345);
    handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
